mod_round_key_ctrl: RTL and testbench
=====================================

# mod_round_key_ctrl

Round-key sequencer sitting between the AES-256 cipher core and the `mod_romKey` round-key ROM. On a start command it walks the ROM through all 15 round-key addresses, ascending for encryption or descending for decryption. It presents each 128-bit key to the core on a valid/ready handshake with the matching round index, then pulses `done`. It is the sole master of the ROM's address and read-enable lines.

## Interface
- `DATA_WIDTH`, 128, round-key width.
- `ADDR_WIDTH`, 4, ROM address width.
- `NUM_KEYS`, 15, number of round keys (AES-256); must be ≤ 2^ADDR_WIDTH.

- `clk` in 1: single clock, all logic on rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: begin a key sequence; sampled only in IDLE.
- `dir` in 1: 0 = encrypt (addr 0→14), 1 = decrypt (addr 14→0); latched with `start`.
- `abort` in 1: cancel the sequence in progress.
- `rom_en` out 1: ROM read strobe (drives ROM `wr_en`).
- `rom_addr` out ADDR_WIDTH: ROM address.
- `rom_data` in DATA_WIDTH: ROM read data, valid the cycle after `rom_en`.
- `key_out` out DATA_WIDTH: current round key.
- `round_idx` out ADDR_WIDTH: ROM address of `key_out`.
- `key_valid` out 1: `key_out` and `round_idx` valid.
- `key_ready` in 1: core accepts key when high with `key_valid`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last key is accepted.

## Operation
- State machine states: IDLE, FETCH, WAIT, PRESENT, DONE.
- IDLE:
  - On `start`: latch `dir`; set `ptr` to 0 (enc) or NUM_KEYS-1 (dec); clear key counter `cnt`; go to FETCH.
  - `start` in any other state is ignored.
- FETCH: `rom_en`=1, `rom_addr`=`ptr`; go to WAIT.
- WAIT: register `rom_data` into `key_out`; set `round_idx`=`ptr`; go to PRESENT.
- PRESENT:
  - `key_valid`=1. `key_out` and `round_idx` stay stable until the handshake.
  - On `key_valid && key_ready`, if `cnt`==NUM_KEYS-1: go to DONE.
  - Otherwise: `ptr` ±1 (by `dir`), `cnt`+1, go to FETCH.
- DONE: `done`=1 for one cycle; go to IDLE.
- Outputs are combinational from state/registers:
  - `rom_en` is 0 except as stated.
  - `rom_addr` shows `ptr` whenever `rom_en`=0.
- `abort` (any non-IDLE state):
  - Next state is IDLE; no `done` pulse.
  - `key_valid` drops next cycle; `key_out` holds its last value.
  - `abort` wins over a same-cycle handshake and over `start`.
- Arithmetic:
  - `ptr` and `cnt` are ADDR_WIDTH wide and never wrap; the `cnt` terminal check prevents stepping past 0 or NUM_KEYS-1.
- Reset (`resetn`=0 at a rising edge, including mid-sequence):
  - State goes to IDLE; `ptr`, `cnt`, `key_out`, `round_idx` all 0.
  - `rom_en`, `key_valid`, `busy`, `done` all 0; no `done` is emitted.

## Timing
- `start` is sampled at edge E0. The machine is in FETCH during cycle 1, WAIT during cycle 2, and `key_valid` first goes high in cycle 3.
- With `key_ready` held high: 3 cycles per key. The last handshake is in cycle 45 and `done` is high in cycle 46.
- `busy` goes high in cycle 1 and low in the cycle after `done`.
- A new `start` is accepted at the earliest in the cycle after `done`.
- Backpressure: `key_valid` stays high for any number of cycles while `key_ready`=0; no ROM access occurs meanwhile.

## Configuration
- `ROUNDKEY_PREFETCH_EN` defined:
  - In PRESENT, on a handshake that is not the last, `rom_en`=1 and `rom_addr`=next `ptr` in that same cycle, and the next state is WAIT (FETCH is skipped).
  - Steady state is 2 cycles per key: first key in cycle 3, last handshake in cycle 31, `done` in cycle 32.
  - `abort` in the handshake cycle still goes to IDLE; the issued ROM read is discarded.
- `ROUNDKEY_PREFETCH_EN` undefined: behaviour exactly as in Operation/Timing (3 cycles per key).

## Test plan
- ROM model for all scenarios: 1-cycle latency, data = {32{addr}}.
- Reset: hold `resetn`=0 for 2 cycles with `start`=1. Required: all outputs 0; IDLE after release; no `rom_en`.
- Encrypt, `key_ready`=1:
  - `start`, `dir`=0. Required: `round_idx` 0..14 in order; key 0 = 128'h0, key 14 = {32{4'hE}}.
  - First `key_valid` in cycle 3; `done` in cycle 46, or cycle 32 with `ROUNDKEY_PREFETCH_EN`.
- Decrypt with backpressure:
  - `dir`=1; `key_ready` low for 4 cycles at each key.
  - Required: `round_idx` 14..0; `key_out` stable while stalled; exactly one `rom_en` per key; single `done`.
- Abort: assert `abort` during the PRESENT of round 5. Required: IDLE and `key_valid`=0 next cycle; no `done`. A new `start` then restarts from addr 0.
- Ignored start: pulse `start` with `dir`=1 while an encrypt sequence is busy. Required: sequence continues ascending, unaffected.
- Reset mid-run: `resetn`=0 for 1 cycle during WAIT of round 7. Required: all outputs 0 next cycle; no `done`.

Source files
------------

// File: rtl/mod_round_key_ctrl.sv
// mod_round_key_ctrl: AES-256 round-key sequencer, sole master of the round-key ROM.
// Define ROUNDKEY_PREFETCH_EN to issue the next ROM read in the handshake cycle (2 cycles/key).
module mod_round_key_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_KEYS   = 15
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  dir,
    input  logic                  abort,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] key_out,
    output logic [ADDR_WIDTH-1:0] round_idx,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_KEYS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    state_t                state, state_nxt;
    logic                  dir_q;
    logic [ADDR_WIDTH-1:0] ptr, cnt, ptr_step;
    logic                  hs, last;

    assign ptr_step  = dir_q ? ptr - ONE : ptr + ONE;
    assign hs        = (state == PRESENT) && key_ready;
    assign last      = (cnt == LAST);
    assign key_valid = (state == PRESENT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_nxt = state;
        rom_en    = 1'b0;
        rom_addr  = ptr;
        case (state)
            IDLE:    state_nxt = start ? FETCH : IDLE;
            FETCH: begin
                rom_en    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:    state_nxt = PRESENT;
            PRESENT: if (key_ready) begin
`ifdef ROUNDKEY_PREFETCH_EN
                rom_en    = !last;
                rom_addr  = last ? ptr : ptr_step;
                state_nxt = last ? DONE : WAIT;
`else
                state_nxt = last ? DONE : FETCH;
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort beats both the handshake and start; a prefetched read is simply dropped
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
            key_out   <= '0;
            round_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                dir_q <= dir;
                ptr   <= dir ? LAST : '0;
                cnt   <= '0;
            end
            if (state == WAIT && !abort) begin
                key_out   <= rom_data;
                round_idx <= ptr;
            end
            if (hs && !last && !abort) begin
                ptr <= ptr_step;
                cnt <= cnt + ONE;
            end
        end
    end
endmodule

// File: tb/tb_mod_round_key_ctrl.sv
// tb_mod_round_key_ctrl: directed bench for the round-key sequencer with a 1-cycle ROM model.
module tb_mod_round_key_ctrl;
    localparam int DW = 128;
    localparam int AW = 4;
    localparam int N  = 15;
`ifdef ROUNDKEY_PREFETCH_EN
    localparam int PER = 2;
`else
    localparam int PER = 3;
`endif
    localparam int DONE_CYC = 3 + PER * (N - 1) + 1;

    logic          clk = 1'b0;
    logic          resetn, start, dir, abort, key_ready;
    logic          rom_en, key_valid, busy, done;
    logic [AW-1:0] rom_addr, round_idx;
    logic [DW-1:0] rom_data, key_out;
    int            tests = 0, fails = 0, cyc = 0;
    int            rom_cnt = 0, done_cnt = 0;

    mod_round_key_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start), .dir(dir), .abort(abort),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .key_out(key_out), .round_idx(round_idx), .key_valid(key_valid),
        .key_ready(key_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rom_en) rom_data <= {32{rom_addr}};
        if (rom_en) rom_cnt <= rom_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [DW-1:0] key(input logic [AW-1:0] a);
        return {32{a}};
    endfunction

    task automatic run(input logic d, input int stall, input int abort_k, input bit ign);
        int k, st, first, dn0, rc0;
        logic [AW-1:0] ex;
        k = 0; st = 0; first = -1; dn0 = done_cnt; rc0 = rom_cnt;
        dir = d; start = 1'b1; cyc = 0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (ign && i == 5) begin start = 1'b1; dir = ~d; end
            else if (ign && i == 6) begin start = 1'b0; dir = d; end
            if (key_valid) begin
                if (first < 0) first = cyc;
                ex = d ? AW'(N - 1 - k) : AW'(k);
                chk("round_idx", round_idx, ex);
                chk("key_out", key_out, key(ex));
                if (k == abort_k) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk("abort_valid", key_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_key_hold", key_out, key(ex));
                    repeat (3) tick();
                    chk("abort_no_done", done_cnt - dn0, 0);
                    return;
                end
                key_ready = (st == stall);
                if (st == stall) begin st = 0; k++; end else st++;
            end else key_ready = 1'b0;
            tick();
        end
        chk("done_seen", done, 1);
        chk("keys_accepted", k, N);
        chk("first_valid_cyc", first, 3);
        if (stall == 0) chk("done_cyc", cyc, DONE_CYC);
        chk("rom_reads", rom_cnt - rc0, N);
        key_ready = 1'b0;
        tick();
        chk("done_pulse_end", done, 0);
        chk("busy_after_done", busy, 0);
        chk("single_done", done_cnt - dn0, 1);
    endtask

    initial begin
        int dn0;
        resetn = 1'b0; start = 1'b1; dir = 1'b0; abort = 1'b0; key_ready = 1'b0;
        tick();
        tick();
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_key_out", key_out, 0);
        chk("rst_round_idx", round_idx, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        start = 1'b0;
        resetn = 1'b1;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_rom_reads", rom_cnt, 0);

        run(1'b0, 0, -1, 1'b0);
        run(1'b1, 4, -1, 1'b0);
        run(1'b0, 0, 5, 1'b0);
        run(1'b0, 0, -1, 1'b0);
        run(1'b0, 0, -1, 1'b1);

        dn0 = done_cnt;
        dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; key_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (rom_en && rom_addr == 4'd7) break;
            tick();
        end
        chk("mid_rst_read7", rom_en, 1);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1; key_ready = 1'b0;
        chk("mid_rst_rom_en", rom_en, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_key_out", key_out, 0);
        chk("mid_rst_round_idx", round_idx, 0);
        chk("mid_rst_key_valid", key_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (3) tick();
        chk("mid_rst_no_done", done_cnt - dn0, 0);
        chk("mid_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
